// File: rtl/hamming_serial_secded_decoder_pkg.sv
// hamming_serial_secded_decoder_pkg: shared SECDED constants and position helpers (package hamming_pkg).
package hamming_pkg;
  localparam int CHECK_BITS_DEF = 4;
  function automatic logic is_pow2(input int p);
    return p != 0 && (p & (p - 1)) == 0;
  endfunction
  function automatic logic is_data_pos(input int p);
    return p != 0 && !is_pow2(p);
  endfunction
  function automatic int pos_to_data_idx(input int p);
    int n;
    n = p - 1;
    for (int i = 0; i < 16; i++) n -= ((1 << i) <= p) ? 1 : 0;
    return n;
  endfunction
endpackage

// File: rtl/hamming_serial_secded_decoder_if.sv
// hamming_serial_secded_decoder_if: serial code bit in, decoded block data and status out.
interface hamming_serial_secded_decoder_if #(parameter int CHECK_BITS = 4);
  localparam int K = 2**CHECK_BITS - CHECK_BITS - 1;
  logic datain;
  logic [K-1:0] data_out;
  logic [CHECK_BITS-1:0] syndrome;
  logic parity_err;
  logic single_err;
  logic double_err;
  logic block_done;
  modport master (output datain, input data_out, syndrome, parity_err, single_err, double_err, block_done);
  modport slave (input datain, output data_out, syndrome, parity_err, single_err, double_err, block_done);
endinterface

// File: rtl/hamming_serial_secded_decoder_acc.sv
// hamming_syndrome_acc: bit position counter plus running parity/syndrome, cleared as each block ends.
module hamming_syndrome_acc #(parameter int CHECK_BITS = 4) (
  input  logic clk,
  input  logic rst_n,
  input  logic datain_i,
  output logic [CHECK_BITS-1:0] pos_o,
  output logic last_o,
  output logic parity_nx_o,
  output logic [CHECK_BITS-1:0] check_nx_o
);
  logic [CHECK_BITS-1:0] pos, check;
  logic parity;
  assign pos_o = pos;
  assign last_o = pos == '1;
  assign parity_nx_o = parity ^ datain_i;
  assign check_nx_o = check ^ (datain_i ? pos : '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos <= '0;
      parity <= 1'b0;
      check <= '0;
    end else begin
      pos <= pos + 1'b1;
      parity <= last_o ? 1'b0 : parity_nx_o;
      check <= last_o ? '0 : check_nx_o;
    end
endmodule

// File: rtl/hamming_serial_secded_decoder.sv
// hamming_serial_secded_decoder: serial extended-Hamming decoder, one code bit per clock.
// Define CORRECT_EN to invert single-error data bits in data_out.
module hamming_serial_secded_decoder
  import hamming_pkg::*;
#(parameter int CHECK_BITS = CHECK_BITS_DEF) (
  input logic clk,
  input logic rst_n,
  hamming_serial_secded_decoder_if.slave bus
);
  localparam int K = 2**CHECK_BITS - CHECK_BITS - 1;
  logic [CHECK_BITS-1:0] pos, check_nx, syn_q;
  logic last, parity_nx, par_q, single_q, double_q, done_q;
  logic [K-1:0] data_q, data_d, fix_d, out_q;
  hamming_syndrome_acc #(.CHECK_BITS(CHECK_BITS)) u_acc (
    .clk(clk), .rst_n(rst_n), .datain_i(bus.datain),
    .pos_o(pos), .last_o(last), .parity_nx_o(parity_nx), .check_nx_o(check_nx)
  );
  always_comb begin
    data_d = is_data_pos(int'(pos)) ? {bus.datain, data_q[K-1:1]} : data_q;
`ifdef CORRECT_EN
    fix_d = (parity_nx && is_data_pos(int'(check_nx))) ? data_d ^ (K'(1) << pos_to_data_idx(int'(check_nx))) : data_d;
`else
    fix_d = data_d;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q <= '0;
      out_q <= '0;
      syn_q <= '0;
      par_q <= 1'b0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= last ? '0 : data_d;
      done_q <= last;
      if (last) begin
        out_q <= fix_d;
        syn_q <= check_nx;
        par_q <= parity_nx;
        single_q <= parity_nx;
        double_q <= !parity_nx && |check_nx;
      end
    end
  assign bus.data_out = out_q;
  assign bus.syndrome = syn_q;
  assign bus.parity_err = par_q;
  assign bus.single_err = single_q;
  assign bus.double_err = double_q;
  assign bus.block_done = done_q;
endmodule

// File: tb/tb_hamming_serial_secded_decoder.sv
// tb_hamming_serial_secded_decoder: directed SECDED blocks with hand-computed expectations.
module tb_hamming_serial_secded_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  hamming_serial_secded_decoder_if #(.CHECK_BITS(4)) bus ();
  hamming_serial_secded_decoder #(.CHECK_BITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [15:0] CLEAN = 16'h69CC;
`ifdef CORRECT_EN
  localparam logic [10:0] P5_DATA = 11'h34D;
`else
  localparam logic [10:0] P5_DATA = 11'h34F;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic expect_out(input string tag, input logic [10:0] d, input logic [3:0] s,
                            input logic p, input logic se, input logic de, input logic done);
    chk({tag, ".data"}, 32'(bus.data_out), 32'(d));
    chk({tag, ".syn"}, 32'(bus.syndrome), 32'(s));
    chk({tag, ".par"}, 32'(bus.parity_err), 32'(p));
    chk({tag, ".single"}, 32'(bus.single_err), 32'(se));
    chk({tag, ".double"}, 32'(bus.double_err), 32'(de));
    chk({tag, ".done"}, 32'(bus.block_done), 32'(done));
  endtask
  task automatic send(input logic [15:0] b, output int pulses, output logic [4:0] pc);
    pulses = 0;
    pc = '0;
    for (int i = 0; i < 16; i++) begin
      bus.datain = b[i];
      if (i == 15) pc = {dut.u_acc.parity, dut.u_acc.check};
      @(negedge clk);
      if (i < 15 && bus.block_done) pulses++;
    end
  endtask
  int pulses;
  logic [4:0] pc;
  initial begin
    bus.datain = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("reset", 11'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    send(CLEAN, pulses, pc);
    chk("clean.acc", 32'(pc), 32'h0);
    chk("clean.pulses", 32'(pulses), 32'h0);
    expect_out("clean", 11'h34D, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(CLEAN, pulses, pc);
    chk("b2b.pulses", 32'(pulses), 32'h0);
    expect_out("b2b", 11'h34D, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(CLEAN ^ 16'h0020, pulses, pc);
    expect_out("p5", P5_DATA, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    send(CLEAN ^ 16'h0220, pulses, pc);
    expect_out("p5p9", 11'h34F ^ 11'h010, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1);
    send(CLEAN ^ 16'h0001, pulses, pc);
    expect_out("p0", 11'h34D, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("p0.done_drop", 32'(bus.block_done), 32'h0);
    chk("p0.hold", 32'(bus.single_err), 32'h1);
    for (int i = 0; i < 6; i++) begin
      bus.datain = CLEAN[i];
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    expect_out("midrst", 11'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst.pos", 32'(dut.u_acc.pos), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(CLEAN, pulses, pc);
    chk("postrst.pulses", 32'(pulses), 32'h0);
    expect_out("postrst", 11'h34D, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
